// File: rtl/stack_dump_pkg.sv
`default_nettype none
// ============================================================================
// Module      : stack_dump_pkg
// Description : State encoding and stack delta codes shared with the CPU.
// Revision    : 1.0 - initial release
// ============================================================================
package stack_dump_pkg;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_POP     = 2'd1,
        S_RESTORE = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    localparam logic [1:0] DELTA_HOLD = 2'b00;
    localparam logic [1:0] DELTA_PUSH = 2'b01;
    localparam logic [1:0] DELTA_POP  = 2'b11;

    function automatic logic [4:0] clamp_count(input logic [4:0] cnt, input logic [4:0] maxn);
        return (cnt > maxn) ? maxn : cnt;
    endfunction

endpackage
`default_nettype wire

// File: rtl/stack_dump.sv
`default_nettype none
// ============================================================================
// Module      : stack_dump
// Description : Streams the top entries of a hardware stack, then pushes them
//               back so the stack ends up exactly as it started.
// Revision    : 1.0 - initial release
// ============================================================================
module stack_dump
    import stack_dump_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 18
) (
    input  logic             clk,
    input  logic             resetq,
    input  logic             start,
    input  logic [4:0]       count,
    output logic             busy,
    output logic             done,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [4:0]       out_index,
    input  logic             cpu_we,
    input  logic [1:0]       cpu_delta,
    input  logic [WIDTH-1:0] cpu_wd,
    input  logic [WIDTH-1:0] stk_rd,
    output logic             stk_we,
    output logic [1:0]       stk_delta,
    output logic [WIDTH-1:0] stk_wd
);

    localparam int         MAXN   = DEPTH + 1;
    localparam logic [4:0] C_MAXN = 5'(MAXN);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [4:0]       r_idx;
    logic [4:0]       w_idx_nxt;
    logic [4:0]       r_n;
    logic [4:0]       w_n_nxt;
    logic             w_fire;
    logic [WIDTH-1:0] r_buf [MAXN];

    assign w_fire    = (r_state == S_POP) && out_ready;
    assign busy      = (r_state != S_IDLE);
    assign out_data  = stk_rd;
    assign out_index = r_idx;

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            r_state <= S_IDLE;
            r_idx   <= 5'd0;
            r_n     <= 5'd0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_n     <= w_n_nxt;
        end
    end

    // Saved entries carry no reset: they are always written before being read.
    always_ff @(posedge clk) begin
        if (w_fire) begin
            r_buf[r_idx] <= stk_rd;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_n_nxt     = r_n;
        stk_we      = 1'b0;
        stk_delta   = DELTA_HOLD;
        stk_wd      = '0;
        out_valid   = 1'b0;
        done        = 1'b0;

        case (r_state)
            S_IDLE: begin
                stk_we    = cpu_we;
                stk_delta = cpu_delta;
                stk_wd    = cpu_wd;
                w_idx_nxt = 5'd0;
                if (start) begin
                    if (count == 5'd0) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_n_nxt     = clamp_count(count, C_MAXN);
                        w_state_nxt = S_POP;
                    end
                end
            end

            S_POP: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    stk_delta = DELTA_POP;
                    // The last slot index doubles as the restore pointer.
                    if (r_idx == r_n - 5'd1) begin
                        w_state_nxt = S_RESTORE;
                    end else begin
                        w_idx_nxt = r_idx + 5'd1;
                    end
                end
            end

            S_RESTORE: begin
                stk_we    = 1'b1;
                stk_delta = DELTA_PUSH;
                stk_wd    = r_buf[r_idx];
                if (r_idx == 5'd0) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_idx_nxt = r_idx - 5'd1;
                end
            end

            S_DONE: begin
                done        = 1'b1;
                w_n_nxt     = 5'd0;
                w_idx_nxt   = 5'd0;
                w_state_nxt = S_IDLE;
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_stack_dump.sv
`default_nettype none
// ============================================================================
// Module      : tb_stack_dump
// Description : Randomized scoreboard bench for stack_dump with a stack model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stack_dump;
    import stack_dump_pkg::*;

    localparam int WIDTH = 16;
    localparam int DEPTH = 18;
    localparam int MAXN  = DEPTH + 1;

    logic             clk       = 1'b0;
    logic             resetq    = 1'b0;
    logic             start     = 1'b0;
    logic [4:0]       count     = 5'd0;
    logic             out_ready = 1'b0;
    logic             cpu_we    = 1'b0;
    logic [1:0]       cpu_delta = DELTA_HOLD;
    logic [WIDTH-1:0] cpu_wd    = '0;
    logic [WIDTH-1:0] stk_rd    = '0;
    logic             busy, done, out_valid, stk_we;
    logic [WIDTH-1:0] out_data, stk_wd;
    logic [4:0]       out_index;
    logic [1:0]       stk_delta;

    always #5 clk = ~clk;

    stack_dump #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .resetq(resetq), .start(start), .count(count),
        .busy(busy), .done(done), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_index(out_index),
        .cpu_we(cpu_we), .cpu_delta(cpu_delta), .cpu_wd(cpu_wd),
        .stk_rd(stk_rd), .stk_we(stk_we), .stk_delta(stk_delta), .stk_wd(stk_wd)
    );

    logic [WIDTH-1:0] stk_q [$];   // physical stack driven by the DUT
    logic [WIDTH-1:0] ref_q [$];   // logical contents the CPU expects
    logic [WIDTH-1:0] exp_d [$];
    logic [4:0]       exp_i [$];

    int  n_checks = 0;
    int  n_errors = 0;
    int  beats, pushes, pops, done_cnt;
    time t_start, t_done;
    logic             stall_prev = 1'b0;
    logic [WIDTH-1:0] prev_d;
    logic [4:0]       prev_i;

    function automatic void chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Stack model: index 0 is the head.
    always @(posedge clk) begin
        logic [WIDTH-1:0] tmp;
        if (!resetq) begin
            stk_q.delete();
        end else if (stk_we && stk_delta == DELTA_PUSH) begin
            stk_q.push_front(stk_wd);
        end else if (!stk_we && stk_delta == DELTA_POP && stk_q.size() > 0) begin
            tmp = stk_q.pop_front();
        end
        stk_rd <= (stk_q.size() > 0) ? stk_q[0] : '0;
    end

    // Monitor: pops expected beats as the DUT presents them.
    always @(negedge clk) begin
        logic [WIDTH-1:0] ed;
        logic [4:0]       ei;
        if (resetq) begin
            if (out_valid && out_ready) begin
                if (exp_d.size() > 0) begin
                    ed = exp_d.pop_front();
                    ei = exp_i.pop_front();
                    chk("beat_data", out_data, ed);
                    chk("beat_index", out_index, ei);
                end
                beats++;
            end
            if (out_valid && !out_ready) begin
                chk("stall_delta", stk_delta, DELTA_HOLD);
                if (stall_prev) begin
                    chk("stall_data", out_data, prev_d);
                    chk("stall_index", out_index, prev_i);
                end
            end
            stall_prev = out_valid && !out_ready;
            prev_d     = out_data;
            prev_i     = out_index;
            if (busy && stk_we && stk_delta == DELTA_PUSH) pushes++;
            if (busy && !stk_we && stk_delta == DELTA_POP) pops++;
            if (done) begin
                done_cnt++;
                t_done = $time;
            end
        end
    end

    task automatic cpu_push(input logic [WIDTH-1:0] v);
        cpu_we = 1'b1; cpu_delta = DELTA_PUSH; cpu_wd = v;
        @(posedge clk); #1;
        cpu_we = 1'b0; cpu_delta = DELTA_HOLD;
        ref_q.push_front(v);
    endtask

    task automatic cpu_pop();
        logic [WIDTH-1:0] tmp;
        chk("cpu_head", stk_rd, ref_q[0]);
        cpu_delta = DELTA_POP;
        @(posedge clk); #1;
        cpu_delta = DELTA_HOLD;
        tmp = ref_q.pop_front();
    endtask

    task automatic compare_stack();
        chk("stack_size", stk_q.size(), ref_q.size());
        for (int i = 0; i < stk_q.size() && i < ref_q.size(); i++)
            chk("stack_entry", stk_q[i], ref_q[i]);
    endtask

    // mode 0: ready high, 1: random ready, 2: ready 1,0,0,1, 3: ready high plus ignored start/cpu push
    task automatic do_dump(input int cnt, input int mode);
        int n;
        int j;
        n = (cnt > MAXN) ? MAXN : cnt;
        for (int i = 0; i < n; i++) begin
            exp_d.push_back(ref_q[i]);
            exp_i.push_back(5'(i));
        end
        beats = 0; pushes = 0; pops = 0; done_cnt = 0;
        start = 1'b1; count = 5'(cnt); out_ready = 1'b0;
        @(posedge clk); t_start = $time; #1;
        start = 1'b0;
        chk("valid_rise", out_valid, (n != 0));
        j = 0;
        while (done_cnt == 0 && j < 400) begin
            case (mode)
                1:       out_ready = 1'($urandom_range(0, 1));
                2:       out_ready = (j == 1 || j == 2) ? 1'b0 : 1'b1;
                default: out_ready = 1'b1;
            endcase
            if (mode == 3 && j == 1) begin
                start = 1'b1; count = 5'd5;
                cpu_we = 1'b1; cpu_delta = DELTA_PUSH; cpu_wd = 16'hDEAD;
            end else begin
                start = 1'b0;
                cpu_we = 1'b0; cpu_delta = DELTA_HOLD;
            end
            @(posedge clk); #1;
            j++;
        end
        start = 1'b0; cpu_we = 1'b0; cpu_delta = DELTA_HOLD; out_ready = 1'b0;
        chk("done_seen", (done_cnt > 0), 1);
        if (mode == 0 || mode == 3)
            chk("done_latency", (t_done - t_start - 5) / 10 + 1, 2 * n + 1);
        repeat (2) @(posedge clk);
        #1;
        chk("done_pulses", done_cnt, 1);
        chk("beats", beats, n);
        chk("pops", pops, n);
        chk("pushes", pushes, n);
        chk("exp_left", exp_d.size(), 0);
        chk("idle_busy", busy, 0);
        compare_stack();
        exp_d.delete();
        exp_i.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int sz, c, j;
        logic [WIDTH-1:0] tmp;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_index", out_index, 0);
        resetq = 1'b1;
        @(posedge clk); #1;

        // Basic three-entry dump followed by a CPU pop
        cpu_push(16'h1111);
        cpu_push(16'h2222);
        cpu_push(16'h3333);
        do_dump(3, 0);
        cpu_pop();

        do_dump(0, 0);
        do_dump(2, 2);

        while (ref_q.size() < 6) cpu_push(16'($urandom));
        do_dump(4, 3);

        while (ref_q.size() < MAXN) cpu_push(16'($urandom));
        do_dump(25, 0);

        for (int it = 0; it < 12; it++) begin
            c = $urandom_range(0, 3);
            for (int k = 0; k < c && ref_q.size() > 0; k++) cpu_pop();
            c = $urandom_range(0, 8);
            for (int k = 0; k < c && ref_q.size() < MAXN; k++) cpu_push(16'($urandom));
            sz = ref_q.size();
            if (sz == MAXN && $urandom_range(0, 1) == 1) c = $urandom_range(MAXN, 31);
            else c = $urandom_range(0, sz);
            do_dump(c, $urandom_range(0, 1));
        end

        // Reset while restoring
        while (ref_q.size() < 5) cpu_push(16'($urandom));
        start = 1'b1; count = 5'd3; out_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        j = 0;
        while (!(busy && stk_we) && j < 50) begin
            @(posedge clk); #1;
            j++;
        end
        chk("reach_restore", (busy && stk_we), 1);
        #1 resetq = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_valid", out_valid, 0);
        chk("arst_done", done, 0);
        cpu_we = 1'b1; cpu_delta = DELTA_PUSH; cpu_wd = 16'hABCD;
        #1;
        chk("arst_stk_we", stk_we, 1);
        chk("arst_stk_delta", stk_delta, DELTA_PUSH);
        chk("arst_stk_wd", stk_wd, 16'hABCD);
        cpu_we = 1'b0; cpu_delta = DELTA_HOLD; out_ready = 1'b0;
        @(posedge clk); #1;
        resetq = 1'b1;
        ref_q.delete();
        exp_d.delete();
        exp_i.delete();
        @(posedge clk); #1;

        cpu_push(16'h0A0A);
        cpu_push(16'h0B0B);
        do_dump(2, 0);
        tmp = stk_rd;
        chk("final_head", tmp, 16'h0B0B);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
